fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the WISC-S25 five-stage pipeline. Owns the PC, issues fetch addresses to the instruction cache and tolerates multi-cycle misses. Applies branch redirects and hazard stalls, and detects HLT. Drives the IF/ID pipeline register that feeds the decode stage and its control decoder.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- BUBBLE_INSTR, 16'h0000, encoding placed in ifid_instr when ifid_valid=0.

Ports:
- clk  in  1  pipeline clock. One clock domain only; all state updates on posedge clk.
- rst_n  in  1  reset, asynchronous and active-low.
- stall  in  1  hazard-unit stall; hold PC and IF/ID contents.
- branch_taken  in  1  taken B/BR resolved in ID; redirect fetch.
- branch_target  in  16  redirect address; valid with branch_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address; always equals the current PC.
- imem_data  in  16  instruction word; valid when imem_ready=1.
- imem_ready  in  1  cache hit or fill complete this cycle.
- ifid_instr  out  16  registered instruction to ID.
- ifid_pc_plus2  out  16  registered PC+2 of that instruction, used by PCS and B.
- ifid_valid  out  1  ifid_instr is a real instruction.
- halted  out  1  HLT fetched; PC frozen.

## Operation
FSM states: FETCH, WAIT, HALT. Reset state is FETCH.

FETCH:
- imem_req=1.
- imem_ready=1, stall=0: IF/ID loads {imem_data, PC+2, valid=1}. PC advances to PC+2.
  - If imem_data[15:12]==4'hF, go to HALT. PC stays at the HLT address.
- imem_ready=0: go to WAIT. PC held. IF/ID loads a bubble unless stall=1.

WAIT:
- imem_req=1 and imem_addr held stable. An in-flight fill is never abandoned.
- On imem_ready=1, return to FETCH and capture as in FETCH, unless a redirect is pending.

HALT:
- imem_req=0. IF/ID loads bubbles.
- halted=1 is combinational from the state.
- Only branch_taken leaves HALT, because an older branch flushes the HLT. Reset also leaves HALT.

Redirect (branch_taken=1):
- In FETCH or HALT: next PC=branch_target, IF/ID loads a bubble, state becomes FETCH.
- In WAIT: latch branch_target into redir_pc and set redir_pend.
  - When imem_ready arrives, discard imem_data, set PC=redir_pc, clear redir_pend, load a bubble, go to FETCH.
  - A second branch_taken while pending overwrites redir_pc.

Priority and arithmetic:
- Priority: rst_n > branch_taken > stall > normal advance.
- branch_taken together with stall: redirect wins, IF/ID loads a bubble.
- PC+2 is 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000 with no flag.
- branch_target[0] is ignored; the PC is forced even.

## Timing
- Reset values:
  - PC=RESET_PC, state=FETCH, redir_pend=0, redir_pc=0.
  - ifid_instr=BUBBLE_INSTR, ifid_pc_plus2=0, ifid_valid=0.
  - halted=0. imem_req=1 after rst_n deasserts.
- Hit latency: the instruction at PC appears on ifid_* on the edge following imem_ready=1.
- Miss of N cycles (imem_ready low for N cycles): N bubbles enter ID, then the instruction.
- Redirect: one bubble, and the target's instruction is in IF/ID two edges after branch_taken (on a hit).
- stall=1 freezes PC, FSM state (except the WAIT→FETCH completion) and all ifid_* registers.
  - If a fill completes during a stall, the word is buffered in a 16-bit hold register.
  - The buffered word is delivered when stall drops; no refetch.
- Asynchronous reset mid-miss returns everything to reset values immediately. Any late imem_ready is ignored.

## Configuration
- FETCH_MISS_WAIT_EN defined: the WAIT state, redirect-pending logic and the stall hold register are compiled in, as above.
- Not defined: the instruction memory is single-cycle and imem_ready is ignored (treated as 1). The FSM has only FETCH and HALT, redirects apply immediately, and the hold register is removed.

## Structure
Shared package wisc_pkg holds:
- opcode constants, including OP_HLT=4'hF, OP_B=4'hC and OP_BR=4'hD
- the BUBBLE_INSTR default
- RESET_PC
- the fetch FSM state enum

One sub-module: pc_reg, a 16-bit register with enable and asynchronous active-low reset. It is instantiated for the PC and for redir_pc.

## Test plan
- Reset then hits with imem_data=16'h1234, then 16'h2345: ifid_instr=16'h1234 with pc_plus2=16'h0002, then 16'h2345 with pc_plus2=16'h0004; ifid_valid=1.
- Miss at PC=0x0010 with imem_ready low 3 cycles: imem_addr is 0x0010 throughout, 3 bubbles (valid=0), then the instruction with pc_plus2=0x0012.
- branch_taken, target 0x0100, during cycle 2 of that miss: the returned word is discarded, one bubble follows, and the next fetch address is 0x0100.
- Fetch 16'hF000 at 0x0020: halted=1, imem_req=0, PC stays 0x0020. A later branch_taken to 0x0040 gives halted=0 and a fetch at 0x0040.
- stall=1 for 2 cycles with branch_taken=1 in the second: no advance in the first cycle, redirect applied in the second, and IF/ID loads a bubble.
- PC=0xFFFE hit: PC wraps to 0x0000 and pc_plus2=0x0000. Asserting rst_n=0 mid-WAIT gives PC=0x0000 and ifid_valid=0 immediately.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC-S25 definitions: opcodes, fetch defaults and the fetch FSM state enum.
package wisc_pkg;
    localparam logic [3:0]  OP_B  = 4'hC;
    localparam logic [3:0]  OP_BR = 4'hD;
    localparam logic [3:0]  OP_HLT = 4'hF;

    localparam logic [15:0] RESET_PC_DEF     = 16'h0000;
    localparam logic [15:0] BUBBLE_INSTR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// 16-bit enabled register with asynchronous active-low reset; used for PC and redir_pc.
module pc_reg #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [15:0] d_i,
    output logic [15:0] q_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q_o <= RST_VAL;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/fetch_stage.sv
// WISC-S25 instruction fetch: PC, I-cache request, redirects, stalls, HLT, IF/ID register.
// FETCH_MISS_WAIT_EN enables multi-cycle miss handling (WAIT state, pending redirect, hold register).
module fetch_stage
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [15:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);
    fetch_state_e state_q;
    logic [15:0]  pc_q, pc_d, pc_plus2, word, redir_tgt, tgt_even;
    logic         pc_en, rdy, fill_done, redirect_now, capture, is_hlt;
    logic         unused_bits;

    assign tgt_even = {branch_target[15:1], 1'b0};

`ifdef FETCH_MISS_WAIT_EN
    logic [15:0] redir_pc_q, hold_q;
    logic        redir_pend_q, hold_vld_q;

    pc_reg #(.RST_VAL(16'h0000)) u_redir_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (branch_taken && state_q == WAIT),
        .d_i   (tgt_even),
        .q_o   (redir_pc_q)
    );

    // A word buffered during a stall counts as a hit until it is consumed.
    assign rdy          = hold_vld_q | imem_ready;
    assign word         = hold_vld_q ? hold_q : imem_data;
    assign fill_done    = (state_q == WAIT) && imem_ready;
    assign redir_tgt    = branch_taken ? tgt_even : redir_pc_q;
    assign redirect_now = (branch_taken && state_q != WAIT) ||
                          (fill_done && (branch_taken || redir_pend_q));
    assign unused_bits  = branch_target[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_pend_q <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_q       <= 16'h0000;
        end else if (redirect_now) begin
            redir_pend_q <= 1'b0;
            hold_vld_q   <= 1'b0;
        end else begin
            if (branch_taken && state_q == WAIT) redir_pend_q <= 1'b1;
            if (capture) begin
                hold_vld_q <= 1'b0;
            end else if (fill_done && stall) begin
                hold_q     <= imem_data;
                hold_vld_q <= 1'b1;
            end
        end
    end
`else
    assign rdy          = 1'b1;
    assign word         = imem_data;
    assign fill_done    = 1'b0;
    assign redir_tgt    = tgt_even;
    assign redirect_now = branch_taken;
    assign unused_bits  = ^{imem_ready, branch_target[0]};
`endif

    assign capture  = !redirect_now && !stall && ((state_q == FETCH && rdy) || fill_done);
    assign is_hlt   = (word[15:12] == OP_HLT);
    assign pc_plus2 = pc_q + 16'd2;
    // HLT keeps the PC on its own address.
    assign pc_en    = redirect_now || (capture && !is_hlt);
    assign pc_d     = redirect_now ? redir_tgt : pc_plus2;

    pc_reg #(.RST_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pc_en),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            ifid_instr    <= BUBBLE_INSTR;
            ifid_pc_plus2 <= 16'h0000;
            ifid_valid    <= 1'b0;
        end else if (redirect_now) begin
            state_q    <= FETCH;
            ifid_instr <= BUBBLE_INSTR;
            ifid_valid <= 1'b0;
        end else if (capture) begin
            state_q       <= is_hlt ? HALT : FETCH;
            ifid_instr    <= word;
            ifid_pc_plus2 <= pc_plus2;
            ifid_valid    <= 1'b1;
        end else begin
            case (state_q)
                FETCH: if (!rdy) begin
                    state_q <= WAIT;
                    if (!stall) begin
                        ifid_instr <= BUBBLE_INSTR;
                        ifid_valid <= 1'b0;
                    end
                end
                WAIT: if (fill_done) begin
                    state_q <= FETCH;
                end else if (branch_taken || !stall) begin
                    ifid_instr <= BUBBLE_INSTR;
                    ifid_valid <= 1'b0;
                end
                HALT: if (!stall) begin
                    ifid_instr <= BUBBLE_INSTR;
                    ifid_valid <= 1'b0;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req  = (state_q != HALT);
    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);
endmodule
